// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded operands, indices, PC and control bundle,
// with stall (hold), flush (bubble), valid tracking and a saturating bubble counter.
module id_ex_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 5,
  parameter int CTRL_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic [DATA_WIDTH-1:0] id_rs_data,
  input  logic [DATA_WIDTH-1:0] id_rt_data,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [REG_WIDTH-1:0]  id_rs,
  input  logic [REG_WIDTH-1:0]  id_rt,
  input  logic [REG_WIDTH-1:0]  id_rd,
  input  logic [CTRL_WIDTH-1:0] id_ctrl,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [DATA_WIDTH-1:0] ex_rs_data,
  output logic [DATA_WIDTH-1:0] ex_rt_data,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [REG_WIDTH-1:0]  ex_rs,
  output logic [REG_WIDTH-1:0]  ex_rt,
  output logic [REG_WIDTH-1:0]  ex_rd,
  output logic [CTRL_WIDTH-1:0] ex_ctrl,
  output logic [15:0]           ex_bubbles
);

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2
  } action_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    if (cnt == 16'hFFFF) begin
      return cnt;
    end else begin
      return cnt + 16'd1;
    end
  endfunction

  action_e               action_s;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] rs_data_q, rs_data_d;
  logic [DATA_WIDTH-1:0] rt_data_q, rt_data_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [REG_WIDTH-1:0]  rs_q, rs_d;
  logic [REG_WIDTH-1:0]  rt_q, rt_d;
  logic [REG_WIDTH-1:0]  rd_q, rd_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [15:0]           bubbles_q, bubbles_d;

  // Action select: flush beats stall, so a stalled instruction can be discarded.
  always_comb begin
    action_s = ACT_LOAD;
    if (flush) begin
      action_s = ACT_BUBBLE;
    end else if (stall) begin
      action_s = ACT_HOLD;
    end else begin
      action_s = ACT_LOAD;
    end
  end

  // Next-state for every field; ctrl is gated by valid so a bubble never carries side effects.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    ctrl_d    = ctrl_q;
    bubbles_d = bubbles_q;
    case (action_s)
      ACT_BUBBLE: begin
        valid_d   = 1'b0;
        pc_d      = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        rs_d      = '0;
        rt_d      = '0;
        rd_d      = '0;
        ctrl_d    = '0;
        bubbles_d = sat_inc(bubbles_q);
      end
      ACT_LOAD: begin
        valid_d   = id_valid;
        pc_d      = id_pc;
        rs_data_d = id_rs_data;
        rt_data_d = id_rt_data;
        imm_d     = id_imm;
        rs_d      = id_rs;
        rt_d      = id_rt;
        rd_d      = id_rd;
        if (id_valid) begin
          ctrl_d    = id_ctrl;
          bubbles_d = bubbles_q;
        end else begin
          ctrl_d    = '0;
          bubbles_d = sat_inc(bubbles_q);
        end
      end
      ACT_HOLD: begin
        valid_d = valid_q;
      end
      default: begin
        valid_d   = 1'b0;
        ctrl_d    = '0;
      end
    endcase
  end

  // Pipeline state flops with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      ctrl_q    <= '0;
      bubbles_q <= 16'h0000;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      ctrl_q    <= ctrl_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_pc      = pc_q;
  assign ex_rs_data = rs_data_q;
  assign ex_rt_data = rt_data_q;
  assign ex_imm     = imm_q;
  assign ex_rs      = rs_q;
  assign ex_rt      = rt_q;
  assign ex_rd      = rd_q;
  assign ex_ctrl    = ctrl_q;
  assign ex_bubbles = bubbles_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: a spec-level expected-state model checked every negedge,
// plus literal expectations for the directed scenarios.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, id_valid;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_ctrl;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [15:0] ex_ctrl, ex_bubbles;

  id_ex_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_ctrl(id_ctrl),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .ex_bubbles(ex_bubbles)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Expected architectural contents of the EX stage.
  bit          m_valid;
  logic [31:0] m_pc, m_rsd, m_rtd, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [15:0] m_ctrl;
  int          m_bub;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_valid = 1'b0; m_pc = 32'd0; m_rsd = 32'd0; m_rtd = 32'd0; m_imm = 32'd0;
    m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0; m_ctrl = 16'd0;
  endtask

  // Effect of one rising edge on the EX stage, given the inputs sampled there.
  task automatic model_step();
    if (!rst_n) begin
      model_clear();
      m_bub = 0;
    end else if (flush) begin
      model_clear();
      m_bub = (m_bub < 65535) ? m_bub + 1 : 65535;
    end else if (!stall) begin
      m_valid = id_valid;
      m_pc = id_pc; m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm;
      m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
      m_ctrl = id_valid ? id_ctrl : 16'd0;
      if (!id_valid) m_bub = (m_bub < 65535) ? m_bub + 1 : 65535;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"},   {63'd0, ex_valid}, {63'd0, m_valid});
    check({tag, ".pc"},      {32'd0, ex_pc},      {32'd0, m_pc});
    check({tag, ".rs_data"}, {32'd0, ex_rs_data}, {32'd0, m_rsd});
    check({tag, ".rt_data"}, {32'd0, ex_rt_data}, {32'd0, m_rtd});
    check({tag, ".imm"},     {32'd0, ex_imm},     {32'd0, m_imm});
    check({tag, ".idx"},     {49'd0, ex_rs, ex_rt, ex_rd}, {49'd0, m_rs, m_rt, m_rd});
    check({tag, ".ctrl"},    {48'd0, ex_ctrl},    {48'd0, m_ctrl});
    check({tag, ".bubbles"}, {48'd0, ex_bubbles}, 64'(m_bub));
    check({tag, ".inv"},     {63'd0, (!ex_valid && ex_ctrl != 16'd0)}, 64'd0);
  endtask

  // Model compare on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) compare_all("model");
  end

  task automatic edge_step();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic [31:0] imm, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] ctrl);
    id_valid = v; id_pc = pc; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_rs = rs; id_rt = rt; id_rd = rd; id_ctrl = ctrl;
  endtask

  task automatic drive_a();
    drive(1'b1, 32'h0040_0010, 32'h1111_1111, 32'h2222_2222, 32'h0000_FFFF,
          5'd5, 5'd6, 5'd7, 16'h1234);
  endtask

  task automatic drive_b();
    drive(1'b1, 32'h0040_0014, 32'hAAAA_0001, 32'h5555_0002, 32'hFFFF_8000,
          5'd9, 5'd10, 5'd31, 16'hABCD);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, {63'd0, ex_valid}, 64'd0);
    check({tag, ".data"},  {ex_pc | ex_rs_data | ex_rt_data | ex_imm, 32'd0}, 64'd0);
    check({tag, ".idx"},   {49'd0, ex_rs, ex_rt, ex_rd}, 64'd0);
    check({tag, ".ctrl"},  {48'd0, ex_ctrl}, 64'd0);
    check({tag, ".bub"},   {48'd0, ex_bubbles}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 16'd0);
    model_clear(); m_bub = 0;
    #1;
    check_zero("reset_init");
    repeat (2) edge_step();
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;

    // Pass-through of A
    drive_a();
    edge_step();
    check("pass.pc",    {32'd0, ex_pc},  64'h0040_0010);
    check("pass.imm",   {32'd0, ex_imm}, 64'h0000_FFFF);
    check("pass.rs",    {59'd0, ex_rs},  64'd5);
    check("pass.ctrl",  {48'd0, ex_ctrl}, 64'h1234);
    check("pass.valid", {63'd0, ex_valid}, 64'd1);

    // Stall 3 edges while ID presents B
    stall = 1'b1; drive_b();
    for (int i = 0; i < 3; i++) begin
      edge_step();
      check("stall.pc",   {32'd0, ex_pc},   64'h0040_0010);
      check("stall.ctrl", {48'd0, ex_ctrl}, 64'h1234);
    end
    stall = 1'b0;
    edge_step();
    check("unstall.pc",   {32'd0, ex_pc},   64'h0040_0014);
    check("unstall.imm",  {32'd0, ex_imm},  64'hFFFF_8000);
    check("unstall.rd",   {59'd0, ex_rd},   64'd31);
    check("unstall.ctrl", {48'd0, ex_ctrl}, 64'hABCD);

    // Flush and stall together with B held
    stall = 1'b1; flush = 1'b1;
    edge_step();
    check("flush.valid", {63'd0, ex_valid},  64'd0);
    check("flush.ctrl",  {48'd0, ex_ctrl},   64'd0);
    check("flush.imm",   {32'd0, ex_imm},    64'd0);
    check("flush.bub",   {48'd0, ex_bubbles}, 64'd1);
    stall = 1'b0; flush = 1'b0;

    // Invalid input: ctrl is suppressed, data still travels, counts as a bubble
    drive(1'b0, 32'h0040_0020, 32'h0, 32'h0, 32'h1, 5'd3, 5'd4, 5'd8, 16'hFFFF);
    edge_step();
    check("inv.valid", {63'd0, ex_valid},  64'd0);
    check("inv.ctrl",  {48'd0, ex_ctrl},   64'd0);
    check("inv.bub",   {48'd0, ex_bubbles}, 64'd2);
    check("inv.pc",    {32'd0, ex_pc},     64'h0040_0020);

    // Asynchronous reset mid-cycle with A loaded
    drive_a();
    edge_step();
    #2 rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_clear(); m_bub = 0;
    #1 rst_n = 1'b1;
    drive_b();
    edge_step();
    check("post_rst.pc", {32'd0, ex_pc}, 64'h0040_0014);

    // Reset asserted mid-stall, held across edges, released while still stalled
    stall = 1'b1; drive_a();
    edge_step();
    #2 rst_n = 1'b0;
    #1;
    check_zero("rst_stall");
    model_clear(); m_bub = 0;
    repeat (2) edge_step();
    #2 rst_n = 1'b1;
    edge_step();
    check_zero("stall_after_rst");
    stall = 1'b0;
    edge_step();
    check("resume.pc", {32'd0, ex_pc}, 64'h0040_0010);

    // Mixed pattern run, covered by the model compare
    for (int i = 0; i < 300; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom, $urandom,
            5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
      edge_step();
    end
    stall = 1'b0; flush = 1'b0;

    // Saturation: 65536 consecutive flushes from a cleared counter
    rst_n = 1'b0;
    #1;
    model_clear(); m_bub = 0;
    edge_step();
    #2 rst_n = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 65536; i++) edge_step();
    check("sat.flush", {48'd0, ex_bubbles}, 64'hFFFF);
    edge_step();
    check("sat.hold", {48'd0, ex_bubbles}, 64'hFFFF);
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 16'h00FF);
    edge_step();
    check("sat.inv", {48'd0, ex_bubbles}, 64'hFFFF);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

Pipeline register between the decode (ID) and execute (EX) stages of the 5-stage pipeline. Captures decoded operands each cycle: register-file read data, the extended immediate from the sign/zero extenders, register indices, PC and the control bundle. Supports hold (stall) and bubble insertion (flush) for the hazard unit, and carries a valid bit so EX can tell real instructions from bubbles.

## Interface
Parameters:
- DATA_WIDTH, 32, width of PC, register data and extended immediate
- REG_WIDTH, 5, register index width
- CTRL_WIDTH, 16, width of the opaque EX/MEM/WB control bundle

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- stall  input  1  hold current contents
- flush  input  1  load a bubble
- id_valid  input  1  ID holds a real instruction
- id_pc  input  DATA_WIDTH  PC of ID instruction
- id_rs_data  input  DATA_WIDTH  rs read data
- id_rt_data  input  DATA_WIDTH  rt read data
- id_imm  input  DATA_WIDTH  extended immediate (sign- or zero-extended upstream)
- id_rs, id_rt, id_rd  input  REG_WIDTH each  register indices
- id_ctrl  input  CTRL_WIDTH  control bundle
- ex_valid  output  1  EX holds a real instruction
- ex_pc, ex_rs_data, ex_rt_data, ex_imm  output  DATA_WIDTH each  registered copies
- ex_rs, ex_rt, ex_rd  output  REG_WIDTH each  registered copies
- ex_ctrl  output  CTRL_WIDTH  registered copy; all-zero when ex_valid=0
- ex_bubbles  output  16  count of bubbles issued since reset

## Operation
- Reset is asynchronous and active-low: while rst_n=0 every output is 0 immediately, regardless of clk. ex_valid=0 and ex_bubbles=0.
- Each rising edge, one action is taken, in priority order:
  - flush=1: load a bubble. ex_valid=0, ex_ctrl=0, ex_rs=ex_rt=ex_rd=0. Data fields (pc, rs_data, rt_data, imm) are also cleared to 0. ex_bubbles increments.
  - stall=1 (flush=0): all outputs hold, including ex_bubbles.
  - otherwise: load. ex_valid←id_valid and every data/index field ← its id_ input. ex_ctrl←id_ctrl when id_valid=1, else 0. When id_valid=0 this counts as a bubble and ex_bubbles increments.
- flush and stall asserted together: flush wins; the stalled instruction is discarded.
- Invariant: ex_valid=0 implies ex_ctrl=0, so a bubble can never write the register file or memory.
- ex_bubbles saturates at 16'hFFFF and never wraps.
- Arithmetic: no width conversion is done here. id_imm arrives already at DATA_WIDTH and passes through unmodified; signed and unsigned immediates are bit-identical in transit.

## Timing
- Latency: one cycle. Inputs sampled at edge N appear on the outputs after edge N and are stable for all of cycle N+1.
- All outputs are driven directly by flops. There is no combinational path from input to output.
- stall held for k cycles: outputs are frozen for k edges, and ID must hold its inputs for the same period.
- flush takes effect on the edge where it is sampled. The instruction present on id_* that cycle is dropped.
- Reset released mid-operation (rst_n rising between edges): the first capture happens on the next rising edge, and no edge-sensitive glitch may alter outputs.
- Reset asserted mid-stall: outputs clear immediately, and the stall has no effect until reset is released.

## Test plan
- Reset: rst_n=0 asynchronously mid-cycle while outputs hold a loaded instruction -> all outputs 0 before the next edge; ex_bubbles=0.
- Pass-through: id_valid=1, id_pc=0x00400010, id_imm=0x0000FFFF, id_rs=5, id_ctrl=16'h1234 -> one edge later ex_pc=0x00400010, ex_imm=0x0000FFFF, ex_rs=5, ex_ctrl=16'h1234, ex_valid=1.
- Stall: load instruction A, then stall=1 for 3 edges while id_* changes to B -> outputs remain A for 3 cycles; B is captured on the first edge with stall=0.
- Flush priority: stall=1 and flush=1 on the same edge with A held -> ex_valid=0, ex_ctrl=0, ex_imm=0; ex_bubbles increments by 1.
- Invalid input: id_valid=0 with id_ctrl=16'hFFFF -> ex_valid=0, ex_ctrl=0, ex_bubbles+1.
- Saturation: force 65536 consecutive flushes -> ex_bubbles stops at 0xFFFF and does not wrap to 0.
